ahb_led_ctrl: RTL and testbench
===============================

Name: ahb_led_ctrl

Overview:
AHB-Lite slave LED controller, parametrised successor to the single-register LED port. Provides NUM_LEDS outputs with readable data, atomic set/clear and byte-lane writes. Adds per-LED hardware blinking driven by a programmable prescaler. Sits on the AHB-Lite interconnect behind the decoder's HSEL, drives board LEDs directly.

Parameters:
NUM_LEDS, 16, number of LED outputs (1..32)
DIV_W, 24, width of blink prescaler counter and BLINK_DIV register (1..32)
DIV_RESET, 24'd4999999, reset value of BLINK_DIV

Ports:
HCLK  input  1  system clock, all logic on rising edge
HRESETn  input  1  reset, synchronous, active-low
HSEL  input  1  slave select from address decoder
HREADY  input  1  bus ready (previous transfer complete)
HTRANS  input  2  transfer type; bit1 = NONSEQ/SEQ
HWRITE  input  1  1 = write
HSIZE  input  3  000 byte, 001 halfword, 010 word
HADDR  input  32  address; only HADDR[4:0] decoded
HWDATA  input  32  write data, data phase
HRDATA  output  32  read data, data phase
HREADYOUT  output  1  always 1 (zero wait states)
HRESP  output  1  always 0 (OKAY)
LED_OUT  output  NUM_LEDS  LED drive
BLINK_PHASE  output  1  current blink phase

Behaviour:
- Clock HCLK; reset HRESETn synchronous, active-low. Only clock and reset; no other clock domains.
- Reset values: LED_DATA=0, BLINK_EN=0, BLINK_DIV=DIV_RESET, prescaler count=0, phase=0, pending-transfer flags=0; hence LED_OUT=0, BLINK_PHASE=0, HRDATA=0.
- Address phase: valid = HSEL & HREADY & HTRANS[1]. On valid, latch HADDR[4:0], HWRITE, HSIZE, set pending flag; else clear flag.
- Data phase (cycle after valid): write commits at the closing edge using HWDATA; read: HRDATA is a combinational mux of latched offset and current registers, 0 when no read pending.
- Byte lanes (little-endian): byte -> lane HADDR[1:0]; halfword -> lanes {1,0} or {3,2} by HADDR[1]; word -> all lanes. Only enabled lanes update. Unaligned halfword/word or HSIZE>010: write ignored, read returns 0. HRESP stays OKAY.
- Register map (offset, access):
  0x00 LED_DATA RW [NUM_LEDS-1:0]
  0x04 BLINK_EN RW [NUM_LEDS-1:0]; 1 = LED blinks
  0x08 BLINK_DIV RW [DIV_W-1:0]
  0x0C LED_SET WO: LED_DATA |= masked wdata; reads 0
  0x10 LED_CLR WO: LED_DATA &= ~masked wdata; reads 0
  0x14 STATUS RO: bit0 = phase; others 0; writes ignored
  0x18-0x1F unmapped: writes ignored, reads 0
- Bits >= NUM_LEDS / >= DIV_W: write ignored, read 0.
- Prescaler: every cycle, if count==BLINK_DIV then count<=0 and phase toggles, else count+1. BLINK_DIV=0 -> phase toggles every cycle. Half-period = BLINK_DIV+1 cycles.
- Write to BLINK_DIV (any lane): count forced to 0 on the same commit edge, phase unchanged; new value governs from next cycle. Overrides terminal-count toggle in that cycle.
- LED_OUT[i] = LED_DATA[i] & (~BLINK_EN[i] | phase), registered (1 cycle after register/phase change). BLINK_PHASE = phase.
- Back-to-back write then read same offset: read returns newly written value (no stall).
- Transfers with HSEL=0, HTRANS IDLE/BUSY, or HREADY=0 leave state untouched.
- Reset asserted mid-transfer: pending transfer discarded, no register modified, all state to reset values at that edge.

Test Plan:
- Reset: hold HRESETn=0 2 cycles with valid write to 0x00 -> LED_OUT=0, HRDATA=0, BLINK_DIV reads DIV_RESET after release.
- Word write 0x0000A5A5 to 0x00, read 0x00 -> HRDATA=0x0000A5A5, LED_OUT=16'hA5A5 one cycle after commit.
- Byte write 0xFF to 0x01 over LED_DATA=0x0000 -> 0xFF00; SET 0x000F -> 0xFF0F; CLR 0x0F00 -> 0xF00F; SET/CLR offsets read 0.
- BLINK_DIV=3, BLINK_EN=0x0001, LED_DATA=0x0003 -> BLINK_PHASE toggles every 4 cycles; LED_OUT alternates 0x0002/0x0003; bit1 steady.
- BLINK_DIV=0 -> phase toggles every cycle; rewriting BLINK_DIV=5 at count 4 of DIV=7 -> count resets to 0, next toggle 6 cycles later.
- Unaligned halfword write to 0x01, word to 0x1C, HTRANS=IDLE write with HSEL=1 -> no register change, HRESP=0, HREADYOUT=1.

Source files
------------

// File: rtl/ahb_led_ctrl_if.sv
// AHB-Lite bus bundle for the LED controller slave.
// The master modport drives the request side and the slave modport drives the response side.
interface ahb_led_ctrl_if;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HREADY, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HREADY, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_led_ctrl.sv
// AHB-Lite LED controller with data, atomic set/clear and byte-lane writes.
// Per-LED blinking is gated by a prescaler phase.
module ahb_led_ctrl #(
  parameter int              NUM_LEDS  = 16,
  parameter int              DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = 24'd4999999
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_led_ctrl_if.slave       bus,
  output logic [NUM_LEDS-1:0] LED_OUT,
  output logic                BLINK_PHASE
);

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_EN     = 3'd1;
  localparam logic [2:0] REG_DIV    = 3'd2;
  localparam logic [2:0] REG_SET    = 3'd3;
  localparam logic [2:0] REG_CLR    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  logic                pend_reg;
  logic [4:0]          addr_reg;
  logic                write_reg;
  logic [2:0]          size_reg;

  logic [NUM_LEDS-1:0] led_data_reg, led_data_next;
  logic [NUM_LEDS-1:0] blink_en_reg, blink_en_next;
  logic [DIV_W-1:0]    blink_div_reg, blink_div_next;
  logic [DIV_W-1:0]    count_reg, count_next;
  logic                phase_reg, phase_next;
  logic [NUM_LEDS-1:0] led_out_reg, led_out_next;

  logic                valid;
  logic                lane_ok;
  logic [3:0]          lane_mask;
  logic [31:0]         bit_mask;
  logic [31:0]         wmask_data;
  logic                wr_commit;
  logic                rd_active;
  logic                div_wr;
  logic [NUM_LEDS-1:0] mask_leds;
  logic [NUM_LEDS-1:0] wd_leds;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign valid = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  // Lane enables come from the latched address phase; illegal sizes or misalignment kill the access.
  always_comb begin
    lane_ok   = 1'b0;
    lane_mask = 4'b0000;
    case (size_reg)
      3'b000: begin
        lane_ok   = 1'b1;
        lane_mask = 4'b0001 << addr_reg[1:0];
      end
      3'b001: begin
        if (!addr_reg[0]) begin
          lane_ok   = 1'b1;
          lane_mask = addr_reg[1] ? 4'b1100 : 4'b0011;
        end
      end
      3'b010: begin
        if (addr_reg[1:0] == 2'b00) begin
          lane_ok   = 1'b1;
          lane_mask = 4'b1111;
        end
      end
      default: begin
        lane_ok   = 1'b0;
        lane_mask = 4'b0000;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign bit_mask[gi*8 +: 8] = {8{lane_mask[gi]}};
    end
  endgenerate

  assign wmask_data = bus.HWDATA & bit_mask;
  assign mask_leds  = bit_mask[NUM_LEDS-1:0];
  assign wd_leds    = wmask_data[NUM_LEDS-1:0];
  assign wr_commit  = pend_reg & write_reg & lane_ok;
  assign rd_active  = pend_reg & ~write_reg & lane_ok;

  always_comb begin
    led_data_next  = led_data_reg;
    blink_en_next  = blink_en_reg;
    blink_div_next = blink_div_reg;
    div_wr         = 1'b0;
    if (wr_commit) begin
      case (addr_reg[4:2])
        REG_DATA: led_data_next = (led_data_reg & ~mask_leds) | wd_leds;
        REG_EN:   blink_en_next = (blink_en_reg & ~mask_leds) | wd_leds;
        REG_DIV: begin
          blink_div_next = (blink_div_reg & ~bit_mask[DIV_W-1:0]) | wmask_data[DIV_W-1:0];
          div_wr         = 1'b1;
        end
        REG_SET:  led_data_next = led_data_reg | wd_leds;
        REG_CLR:  led_data_next = led_data_reg & ~wd_leds;
        default:  ;
      endcase
    end
  end

  // A divider write restarts the count without touching the phase, even on a terminal count.
  always_comb begin
    count_next = count_reg + DIV_W'(1);
    phase_next = phase_reg;
    if (div_wr) begin
      count_next = '0;
    end else if (count_reg == blink_div_reg) begin
      count_next = '0;
      phase_next = ~phase_reg;
    end
  end

  assign led_out_next = led_data_reg & (~blink_en_reg | {NUM_LEDS{phase_reg}});

  always_comb begin
    rdata = 32'h0;
    if (rd_active) begin
      case (addr_reg[4:2])
        REG_DATA:   rdata[NUM_LEDS-1:0] = led_data_reg;
        REG_EN:     rdata[NUM_LEDS-1:0] = blink_en_reg;
        REG_DIV:    rdata[DIV_W-1:0]    = blink_div_reg;
        REG_STATUS: rdata[0]            = phase_reg;
        default:    rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_reg      <= 1'b0;
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      size_reg      <= '0;
      led_data_reg  <= '0;
      blink_en_reg  <= '0;
      blink_div_reg <= DIV_RESET;
      count_reg     <= '0;
      phase_reg     <= 1'b0;
      led_out_reg   <= '0;
    end else begin
      pend_reg <= valid;
      if (valid) begin
        addr_reg  <= bus.HADDR[4:0];
        write_reg <= bus.HWRITE;
        size_reg  <= bus.HSIZE;
      end
      led_data_reg  <= led_data_next;
      blink_en_reg  <= blink_en_next;
      blink_div_reg <= blink_div_next;
      count_reg     <= count_next;
      phase_reg     <= phase_next;
      led_out_reg   <= led_out_next;
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign LED_OUT       = led_out_reg;
  assign BLINK_PHASE   = phase_reg;

  assign unused_bits = ^{wmask_data, bus.HADDR[31:5], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_led_ctrl.sv
// Directed bench for ahb_led_ctrl: bus accesses, byte lanes, set/clear, blink timing.
module tb_ahb_led_ctrl;
  logic        HCLK;
  logic        HRESETn;
  logic [15:0] led_out;
  logic        blink_phase;
  logic [31:0] rd_val;
  int          checks;
  int          errors;

  ahb_led_ctrl_if bus();

  ahb_led_ctrl dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (bus),
    .LED_OUT     (led_out),
    .BLINK_PHASE (blink_phase)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HREADY = 1'b1;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HADDR  = 32'h0;
  endtask

  // Returns at the negedge inside the data phase; the write commits on the next posedge.
  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HREADY = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
    @(negedge HCLK);
    bus_idle();
    bus.HWDATA = data;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size, output logic [31:0] data);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HREADY = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
    @(negedge HCLK);
    bus_idle();
    data = bus.HRDATA;
  endtask

  task automatic pulse_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    HRESETn = 1'b0;
    bus.HWDATA = 32'h0;
    bus_idle();

    // Valid write attempted while reset is held.
    wr(32'h0, 3'b010, 32'h0000FFFF);
    chk("reset_hrdata", bus.HRDATA, 32'h0);
    chk("reset_led", {16'h0, led_out}, 32'h0);
    chk("reset_phase", {31'h0, blink_phase}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd(32'h0, 3'b010, rd_val);
    chk("reset_data", rd_val, 32'h0);
    rd(32'h8, 3'b010, rd_val);
    chk("reset_div", rd_val, 32'h004C4B3F);

    wr(32'h0, 3'b010, 32'h0000A5A5);
    @(posedge HCLK); #1;
    chk("led_latency", {16'h0, led_out}, 32'h0);
    @(posedge HCLK); #1;
    chk("led_word", {16'h0, led_out}, 32'h0000A5A5);
    rd(32'h0, 3'b010, rd_val);
    chk("rd_word", rd_val, 32'h0000A5A5);

    wr(32'h0, 3'b010, 32'h0);
    wr(32'h1, 3'b000, 32'h0000FF00);
    rd(32'h0, 3'b010, rd_val);
    chk("byte_lane1", rd_val, 32'h0000FF00);
    wr(32'hC, 3'b010, 32'h0000000F);
    rd(32'h0, 3'b010, rd_val);
    chk("set", rd_val, 32'h0000FF0F);
    wr(32'h10, 3'b010, 32'h00000F00);
    rd(32'h0, 3'b010, rd_val);
    chk("clr", rd_val, 32'h0000F00F);
    rd(32'hC, 3'b010, rd_val);
    chk("rd_set_zero", rd_val, 32'h0);
    rd(32'h10, 3'b010, rd_val);
    chk("rd_clr_zero", rd_val, 32'h0);
    wr(32'h2, 3'b001, 32'hFFFF0000);
    rd(32'h0, 3'b010, rd_val);
    chk("half_upper_ignored", rd_val, 32'h0000F00F);

    // Blink with divider 3: half-period of four cycles, phase starts low.
    wr(32'h4, 3'b010, 32'h00000001);
    wr(32'h0, 3'b010, 32'h00000003);
    wr(32'h8, 3'b010, 32'h00000003);
    @(posedge HCLK); #1;
    chk("blink_phase_k0", {31'h0, blink_phase}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge HCLK); #1;
      chk($sformatf("blink_phase_k%0d", k), {31'h0, blink_phase},
          (k >= 4 && k < 8) ? 32'h1 : 32'h0);
      chk($sformatf("blink_led_k%0d", k), {16'h0, led_out},
          (k >= 5) ? 32'h3 : 32'h2);
    end
    rd(32'h14, 3'b010, rd_val);
    chk("status_rd", rd_val, {31'h0, blink_phase});

    // Divider 0 toggles every cycle.
    pulse_reset();
    wr(32'h8, 3'b010, 32'h0);
    @(posedge HCLK); #1;
    chk("div0_k0", {31'h0, blink_phase}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge HCLK); #1;
      chk($sformatf("div0_k%0d", k), {31'h0, blink_phase}, (k % 2 == 1) ? 32'h1 : 32'h0);
    end

    // Divider 7, rewritten to 5 while the count is at 4.
    pulse_reset();
    wr(32'h8, 3'b010, 32'h7);
    repeat (3) @(negedge HCLK);
    wr(32'h8, 3'b010, 32'h5);
    @(posedge HCLK); #1;
    chk("rediv_k0", {31'h0, blink_phase}, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge HCLK); #1;
      chk($sformatf("rediv_k%0d", k), {31'h0, blink_phase}, (k == 6) ? 32'h1 : 32'h0);
    end
    wr(32'h8, 3'b010, 32'hFFFFFFFF);
    rd(32'h8, 3'b010, rd_val);
    chk("div_width", rd_val, 32'h00FFFFFF);

    // Ignored accesses.
    pulse_reset();
    wr(32'h0, 3'b010, 32'hFFFF1234);
    rd(32'h0, 3'b010, rd_val);
    chk("led_width", rd_val, 32'h00001234);
    wr(32'h1, 3'b001, 32'hFFFFFFFF);
    chk("unaligned_hresp", {31'h0, bus.HRESP}, 32'h0);
    chk("unaligned_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    rd(32'h0, 3'b010, rd_val);
    chk("unaligned_half_ignored", rd_val, 32'h00001234);
    rd(32'h1, 3'b001, rd_val);
    chk("unaligned_half_rd", rd_val, 32'h0);
    wr(32'h1C, 3'b010, 32'hFFFFFFFF);
    rd(32'h1C, 3'b010, rd_val);
    chk("unmapped_rd", rd_val, 32'h0);
    rd(32'h0, 3'b011, rd_val);
    chk("bad_size_rd", rd_val, 32'h0);

    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = 32'h0;
    @(negedge HCLK);
    bus_idle(); bus.HWDATA = 32'h0000FFFF;
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HREADY = 1'b0;
    @(negedge HCLK);
    bus_idle(); bus.HWDATA = 32'h0000FFFF;
    rd(32'h0, 3'b010, rd_val);
    chk("idle_noready_ignored", rd_val, 32'h00001234);

    // Back-to-back write then read of the same register.
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = 3'b010; bus.HADDR = 32'h0;
    @(negedge HCLK);
    bus.HWDATA = 32'h0000BEEF; bus.HWRITE = 1'b0;
    @(negedge HCLK);
    bus_idle();
    chk("b2b_read", bus.HRDATA, 32'h0000BEEF);

    // Reset arriving in the data phase discards the write.
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'h4;
    @(negedge HCLK);
    bus_idle(); bus.HWDATA = 32'h0000FFFF; HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd(32'h4, 3'b010, rd_val);
    chk("midxfer_reset_en", rd_val, 32'h0);
    rd(32'h0, 3'b010, rd_val);
    chk("midxfer_reset_data", rd_val, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
